// File: rtl/split_ram_writer_if.sv
// Stream-in / bank-write bundle for split_ram_writer.
// master = upstream layer engine side, slave = the writer itself.
interface split_ram_writer_if #(
  parameter int NUM_RAMS  = 7,
  parameter int RAM_DEPTH = 256,
  parameter int RAM_WIDTH = 16
);
  localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  logic                 start;
  logic [RAM_WIDTH-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [RAM_WIDTH-1:0] data_wr;
  logic [NUM_RAMS-1:0]  data_layer_wren;
  logic [AW-1:0]        addr;
  logic                 busy;
  logic                 done;

  modport master (
    output start, in_data, in_valid,
    input  in_ready, data_wr, data_layer_wren, addr, busy, done
  );

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, data_wr, data_layer_wren, addr, busy, done
  );
endinterface

// File: rtl/split_ram_writer.sv
// Writes one frame into NUM_RAMS interleaved banks (sample k -> bank k%NUM_RAMS, word k/NUM_RAMS), 1-cycle write latency,
// one sample/cycle in RUN; in_ready low outside RUN so upstream holds data. SPLIT_RAM_WRITER_RELU_EN clamps negatives to 0.
module split_ram_writer #(
  parameter int NUM_RAMS    = 7,
  parameter int RAM_DEPTH   = 256,
  parameter int RAM_WIDTH   = 16,
  parameter int FRAME_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  split_ram_writer_if.slave bus
);
  localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int BW = (NUM_RAMS > 1) ? $clog2(NUM_RAMS) : 1;
  localparam logic [BW-1:0]       LAST_BANK  = BW'(NUM_RAMS - 1);
  localparam logic [AW-1:0]       LAST_WORD  = AW'(FRAME_WORDS - 1);
  localparam logic [NUM_RAMS-1:0] WREN_BANK0 = NUM_RAMS'(1);

  generate
    if (FRAME_WORDS < 1 || FRAME_WORDS > RAM_DEPTH) begin : g_bad_frame_words
      $error("split_ram_writer: FRAME_WORDS must be in 1..RAM_DEPTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [BW-1:0]        r_bank;
  logic [AW-1:0]        r_word;
  logic                 r_in_ready;
  logic [RAM_WIDTH-1:0] r_data_wr;
  logic [NUM_RAMS-1:0]  r_wren;
  logic [AW-1:0]        r_addr;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_accept;
  logic [RAM_WIDTH-1:0] w_wr_data;

  assign w_accept = bus.in_valid && r_in_ready;

`ifdef SPLIT_RAM_WRITER_RELU_EN
  assign w_wr_data = bus.in_data[RAM_WIDTH-1] ? '0 : bus.in_data;
`else
  assign w_wr_data = bus.in_data;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_bank     <= '0;
      r_word     <= '0;
      r_in_ready <= 1'b0;
      r_data_wr  <= '0;
      r_wren     <= '0;
      r_addr     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      // write enable and done are single-cycle pulses unless re-armed below
      r_wren <= '0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state    <= S_RUN;
            r_bank     <= '0;
            r_word     <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_data_wr <= w_wr_data;
            r_wren    <= WREN_BANK0 << r_bank;
            r_addr    <= r_word;
            if (r_bank == LAST_BANK) begin
              r_bank <= '0;
              if (r_word == LAST_WORD) begin
                r_word     <= '0;
                r_state    <= S_DONE;
                r_in_ready <= 1'b0;
                r_done     <= 1'b1;
              end else begin
                r_word <= r_word + AW'(1);
              end
            end else begin
              r_bank <= r_bank + BW'(1);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready        = r_in_ready;
  assign bus.data_wr         = r_data_wr;
  assign bus.data_layer_wren = r_wren;
  assign bus.addr            = r_addr;
  assign bus.busy            = r_busy;
  assign bus.done            = r_done;
endmodule

// File: tb/tb_split_ram_writer.sv
// Scoreboard bench for split_ram_writer: small frame (7 banks x 4 words) plus a full-depth instance (7 x 256).
module tb_split_ram_writer;
  localparam int N  = 7;
  localparam int D  = 256;
  localparam int W  = 16;
  localparam int F  = 4;
  localparam int FB = 256;
`ifdef SPLIT_RAM_WRITER_RELU_EN
  localparam bit RELU_ON = 1'b1;
`else
  localparam bit RELU_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  split_ram_writer_if #(.NUM_RAMS(N), .RAM_DEPTH(D), .RAM_WIDTH(W)) sif ();
  split_ram_writer_if #(.NUM_RAMS(N), .RAM_DEPTH(D), .RAM_WIDTH(W)) bif ();

  split_ram_writer #(.NUM_RAMS(N), .RAM_DEPTH(D), .RAM_WIDTH(W), .FRAME_WORDS(F))
    u_dut (.clk(clk), .rst(rst), .bus(sif.slave));
  split_ram_writer #(.NUM_RAMS(N), .RAM_DEPTH(D), .RAM_WIDTH(W), .FRAME_WORDS(FB))
    u_big (.clk(clk), .rst(rst), .bus(bif.slave));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0] wren;
    logic [7:0]   addr;
    logic [W-1:0] data;
    logic         done;
  } wr_t;

  wr_t          exp_q[$];
  logic [W-1:0] tx_q[$];
  logic [W-1:0] mem [N][F];
  int           k = 0;
  int           writes = 0;
  int           dones = 0;
  bit           acc_flag = 1'b0;
  logic [N-1:0] first_wren;
  logic [7:0]   first_addr;

  int           big_sent = 0;
  int           big_writes = 0;
  int           big_max_addr = 0;
  logic [7:0]   big_done_addr = '0;
  logic [N-1:0] big_done_wren = '0;
  int           big_dones = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference rule: negative samples clamp to zero when ReLU is built in
  function automatic logic [W-1:0] ref_val(input logic [W-1:0] d);
    if (RELU_ON && $signed(d) < 0) return '0;
    return d;
  endfunction

  // small-instance monitor: compare current write, then predict the accept at the coming edge
  always @(negedge clk) begin
    wr_t e;
    if (sif.data_layer_wren != '0) begin
      writes++;
      if (writes == 1) begin
        first_wren = sif.data_layer_wren;
        first_addr = sif.addr;
      end
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(sif.data_layer_wren), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wren", 32'(sif.data_layer_wren), 32'(e.wren));
        chk("addr", 32'(sif.addr), 32'(e.addr));
        chk("data", 32'(sif.data_wr), 32'(e.data));
        chk("done_with_write", 32'(sif.done), 32'(e.done));
      end
      for (int b = 0; b < N; b++)
        if (sif.data_layer_wren[b] && sif.addr < F) mem[b][sif.addr] = sif.data_wr;
    end else begin
      if (exp_q.size() != 0) begin
        chk("write_missing", 32'(exp_q.size()), 32'd0);
        void'(exp_q.pop_front());
      end
      chk("done_without_write", 32'(sif.done), 32'd0);
    end
    if (sif.done === 1'b1) dones++;
    acc_flag = rst && sif.in_valid && sif.in_ready;
    if (acc_flag) begin
      e.wren = N'(1) << (k % N);
      e.addr = 8'(k / N);
      e.data = ref_val(sif.in_data);
      e.done = (k == N * F - 1);
      exp_q.push_back(e);
      k = (k == N * F - 1) ? 0 : k + 1;
    end
  end

  // full-depth monitor: sample i is driven as value i, so write j must carry j
  always @(negedge clk) begin
    if (bif.data_layer_wren != '0) begin
      chk("big_wren", 32'(bif.data_layer_wren), 32'(N'(1) << (big_writes % N)));
      chk("big_addr", 32'(bif.addr), 32'(big_writes / N));
      chk("big_data", 32'(bif.data_wr), 32'(big_writes & 16'hFFFF));
      if (int'(bif.addr) > big_max_addr) big_max_addr = int'(bif.addr);
      big_writes++;
    end
    if (bif.done === 1'b1) begin
      big_dones++;
      big_done_addr = bif.addr;
      big_done_wren = bif.data_layer_wren;
    end
    if (rst && bif.in_valid && bif.in_ready) big_sent++;
  end

  task automatic clear_frame();
    writes = 0;
    dones  = 0;
    k      = 0;
    for (int b = 0; b < N; b++)
      for (int w = 0; w < F; w++) mem[b][w] = 16'hDEAD;
  endtask

  task automatic load_ramp();
    tx_q.delete();
    for (int i = 0; i < N * F; i++) tx_q.push_back(W'(i));
  endtask

  task automatic start_frame(input bit hold);
    @(posedge clk); #1;
    chk("ready_low_in_idle", 32'(sif.in_ready), 32'd0);
    clear_frame();
    sif.start = 1'b1;
    @(posedge clk); #1;
    if (!hold) sif.start = 1'b0;
    chk("ready_after_start", 32'(sif.in_ready), 32'd1);
    chk("busy_after_start", 32'(sif.busy), 32'd1);
  endtask

  task automatic stream(input int n, input int bubble_pct);
    int sent  = 0;
    int guard = 0;
    while (sent < n && guard < 2000) begin
      @(posedge clk); #1;
      if (acc_flag) sent++;
      if (sent < n) begin
        sif.in_valid = ($urandom_range(99) >= bubble_pct);
        sif.in_data  = tx_q[sent];
      end else begin
        sif.in_valid = 1'b0;
      end
      guard++;
    end
    if (sent < n) chk("stream_timeout", 32'(sent), 32'(n));
  endtask

  task automatic end_frame();
    chk("done_on_last", 32'(sif.done), 32'd1);
    chk("ready_in_done", 32'(sif.in_ready), 32'd0);
    chk("busy_in_done", 32'(sif.busy), 32'd1);
    @(posedge clk); #1;
    sif.start = 1'b0;
    chk("busy_after_done", 32'(sif.busy), 32'd0);
    chk("done_single_cycle", 32'(sif.done), 32'd0);
    chk("writes_per_frame", 32'(writes), 32'(N * F));
    chk("dones_per_frame", 32'(dones), 32'd1);
    chk("first_wren", 32'(first_wren), 32'd1);
    chk("first_addr", 32'(first_addr), 32'd0);
  endtask

  task automatic check_ramp_mem();
    for (int b = 0; b < N; b++)
      for (int w = 0; w < F; w++)
        chk("mem_ramp", 32'(mem[b][w]), 32'(N * w + b));
  endtask

  initial begin
    sif.start = 1'b0; sif.in_valid = 1'b0; sif.in_data = '0;
    bif.start = 1'b0; bif.in_valid = 1'b0; bif.in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(sif.in_ready), 32'd0);
    chk("rst_wren", 32'(sif.data_layer_wren), 32'd0);
    chk("rst_addr", 32'(sif.addr), 32'd0);
    chk("rst_data", 32'(sif.data_wr), 32'd0);
    chk("rst_busy", 32'(sif.busy), 32'd0);
    chk("rst_done", 32'(sif.done), 32'd0);
    rst = 1'b1;

    // basic frame, continuous valid
    load_ramp();
    start_frame(1'b0);
    stream(N * F, 0);
    end_frame();
    check_ramp_mem();
    chk("bank3_word2", 32'(mem[3][2]), 32'd17);
    chk("bank6_word3", 32'(mem[6][3]), 32'd27);

    // random bubbles on in_valid
    start_frame(1'b0);
    stream(N * F, 40);
    end_frame();
    check_ramp_mem();

    // start held high across the whole frame, then a fresh frame
    start_frame(1'b1);
    stream(N * F, 30);
    end_frame();
    repeat (3) begin
      @(posedge clk); #1;
      chk("stays_idle", 32'(sif.busy), 32'd0);
    end
    start_frame(1'b0);
    stream(N * F, 20);
    end_frame();
    check_ramp_mem();

    // reset after 10 accepts
    start_frame(1'b0);
    stream(10, 0);
    rst = 1'b0;
    sif.in_valid = 1'b0;
    k = 0;
    @(posedge clk); #1;
    chk("midrst_ready", 32'(sif.in_ready), 32'd0);
    chk("midrst_wren", 32'(sif.data_layer_wren), 32'd0);
    chk("midrst_addr", 32'(sif.addr), 32'd0);
    chk("midrst_busy", 32'(sif.busy), 32'd0);
    chk("midrst_data", 32'(sif.data_wr), 32'd0);
    rst = 1'b1;
    start_frame(1'b0);
    stream(N * F, 10);
    end_frame();
    check_ramp_mem();

    // sign handling on the first four samples
    load_ramp();
    tx_q[0] = 16'hFFFF; tx_q[1] = 16'h8000; tx_q[2] = 16'h7FFF; tx_q[3] = 16'h0001;
    start_frame(1'b0);
    stream(N * F, 0);
    end_frame();
    chk("relu_ffff", 32'(mem[0][0]), RELU_ON ? 32'd0 : 32'hFFFF);
    chk("relu_8000", 32'(mem[1][0]), RELU_ON ? 32'd0 : 32'h8000);
    chk("relu_7fff", 32'(mem[2][0]), 32'h7FFF);
    chk("relu_0001", 32'(mem[3][0]), 32'h0001);

    // full-depth frame on the 256-word instance
    @(posedge clk); #1;
    bif.start = 1'b1;
    @(posedge clk); #1;
    bif.start = 1'b0;
    begin
      int guard = 0;
      while (big_dones == 0 && guard < 3000) begin
        bif.in_valid = (big_sent < N * FB);
        bif.in_data  = W'(big_sent);
        @(posedge clk); #1;
        guard++;
      end
      bif.in_valid = 1'b0;
      if (big_dones == 0) chk("big_done_timeout", 32'(guard), 32'd0);
    end
    @(posedge clk); #1;
    chk("big_writes", 32'(big_writes), 32'(N * FB));
    chk("big_last_addr", 32'(big_done_addr), 32'd255);
    chk("big_last_bank", 32'(big_done_wren), 32'(1 << (N - 1)));
    chk("big_max_addr", 32'(big_max_addr), 32'd255);
    chk("big_dones", 32'(big_dones), 32'd1);
    chk("big_busy_end", 32'(bif.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/split_ram_writer.md
# split_ram_writer

Stream-to-bank writer for the banked feature-map RAMs. It accepts a valid/ready stream of samples from a layer engine and writes one frame into `NUM_RAMS` parallel RAM banks. Writes interleave across banks: sample k goes to bank k mod `NUM_RAMS`, word k / `NUM_RAMS`. It drives the write side (`data_wr`, `data_layer_wren`, `addr`) of the split RAM that pooling and convolution layers later read back.

## Interface
Parameters:
- `NUM_RAMS`, 7: number of banks; width of the one-hot write enable.
- `RAM_DEPTH`, 256: words per bank; `addr` width is $clog2(RAM_DEPTH).
- `RAM_WIDTH`, 16: sample and bank word width; samples are signed two's complement.
- `FRAME_WORDS`, 256: words written per bank per frame.
  - Must satisfy 1 ≤ `FRAME_WORDS` ≤ `RAM_DEPTH`.
  - Elaboration-time `$error` otherwise.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a frame; sampled only in IDLE.
- `in_data`  in  RAM_WIDTH  input sample.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  writer accepts a sample this cycle.
- `data_wr`  out  RAM_WIDTH  write data to all banks.
- `data_layer_wren`  out  NUM_RAMS  one-hot bank write enable; all zero means no write.
- `addr`  out  $clog2(RAM_DEPTH)  word address, shared by all banks.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse at frame completion.

## Operation
- States:
  - IDLE: `in_ready`=0.
    - `start`=1 moves to RUN and clears `bank_cnt` and `word_cnt` to 0.
  - RUN: `in_ready`=1.
    - Accept occurs when `in_valid`&&`in_ready`.
    - On accept, register `data_wr`=in_data, `data_layer_wren`=1<<bank_cnt, `addr`=word_cnt.
    - Then advance `bank_cnt`; it wraps at `NUM_RAMS`-1 to 0 and increments `word_cnt` on wrap.
    - The accept of sample `NUM_RAMS`*`FRAME_WORDS`-1 (bank `NUM_RAMS`-1, word `FRAME_WORDS`-1) moves to DONE.
  - DONE: `in_ready`=0; `done`=1 for this single cycle; next state IDLE.
- With no accept in a cycle, `data_layer_wren` is 0 the next cycle. `data_wr` and `addr` hold their last values.
- `start` in RUN or DONE is ignored. `start` asserted on the same cycle DONE returns to IDLE is also ignored; a new frame needs `start` while in IDLE.
- `in_valid` while `in_ready`=0 is not consumed. Upstream must hold its data.
- Counters never exceed `NUM_RAMS`-1 and `FRAME_WORDS`-1. `addr` never exceeds `FRAME_WORDS`-1.
- Reset values: state IDLE; counters 0; `in_ready`=0, `data_wr`=0, `data_layer_wren`=0, `addr`=0, `busy`=0, `done`=0.
- Reset asserted mid-frame: return to IDLE the next edge with all outputs at reset values. The partial frame is abandoned and nothing is flushed.

## Timing
- `in_ready` is a registered function of state. It is high from the cycle after `start` is sampled in IDLE.
- Write latency is 1: a sample accepted at edge T appears on `data_wr`/`addr`/`data_layer_wren` for the cycle after edge T. The RAM captures it at edge T+1.
- Throughput is one sample per cycle at sustained `in_valid`.
- A frame takes `NUM_RAMS`*`FRAME_WORDS` accepts.
- The last write is visible in the same cycle as `done`=1. The RAM captures it at the edge ending that cycle.
- `busy` falls in the cycle after the `done` pulse.

## Configuration
- `SPLIT_RAM_WRITER_RELU_EN` defined:
  - A sample with MSB=1 (negative) is written as 0.
  - Non-negative samples pass unchanged.
  - No added latency.
- Not defined: samples are written unmodified.

## Test plan
- Basic frame, `NUM_RAMS`=7, `FRAME_WORDS`=4: pulse `start`, then stream 0..27 with `in_valid` held high.
  - Bank b word w holds 7w+b: bank 3 word 2 = 17, bank 6 word 3 = 27.
  - `done` pulses exactly once, in the cycle bank 6 word 3 is written.
- Backpressure and bubbles: toggle `in_valid` pseudo-randomly.
  - Every `in_valid`=0 cycle produces `data_layer_wren`=0 the next cycle.
  - Final memory contents are identical to the basic-frame case.
- Start handling: `start` held high for the whole frame.
  - Counters are not cleared mid-frame and exactly 28 writes occur.
  - After `done`, a fresh `start` in IDLE runs a second frame that begins again at bank 0 word 0.
- Reset mid-frame: drop `rst` to 0 after 10 accepts.
  - The next cycle shows `in_ready`=0, `data_layer_wren`=0, `addr`=0, `busy`=0.
  - A new `start` restarts at bank 0 word 0.
- ReLU with macro defined: stream 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001.
  - Written values are 0, 0, 16'h7FFF, 16'h0001.
  - Without the macro, all four are written unchanged.
- Boundary, `FRAME_WORDS`=`RAM_DEPTH`=256:
  - The last write lands at `addr`=255 in bank 6.
  - `addr` never wraps to 0 within the frame.
